// File: rtl/frame_swap_scheduler.sv
// rtl/frame_swap_scheduler.sv - double-buffer bank swap controller for the shared pixel RAM
// Optional FRAME_PAUSE_EN adds i_pause, which freezes the display timer and inhibits swaps/underruns.
module frame_swap_scheduler #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int TICK_DIV = 48000,
  parameter int DELAY_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_last,
  input  logic [DELAY_W-1:0] i_wr_delay_ms,
  output logic [ADDR_W:0]   o_ram_w_addr,
  output logic [DATA_W-1:0] o_ram_w_data,
  output logic              o_ram_w_enable,
  output logic              o_read_bank,
`ifdef FRAME_PAUSE_EN
  input  logic              i_pause,
`endif
  input  logic              i_drv_frame_end,
  output logic              o_swap_stb,
  output logic [7:0]        o_frame_count,
  output logic              o_underrun,
  output logic              o_wr_error
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

  typedef enum logic {FILL, READY} state_t;

  state_t              state, state_next;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DELAY_W-1:0]  ms_remaining;
  logic [DELAY_W-1:0]  pending_delay;
  logic [PRE_W-1:0]    prescaler;
  logic                pause;
  logic                accept, at_end, fill_done, overflow;
  logic                tick, timer_idle, swap, underrun_now;

`ifdef FRAME_PAUSE_EN
  assign pause = i_pause;
`else
  assign pause = 1'b0;
`endif

  always_comb begin
    accept       = i_wr_valid && (state == FILL);
    at_end       = (wr_addr == {ADDR_W{1'b1}});
    fill_done    = accept && (i_wr_last || at_end);
    overflow     = accept && at_end && !i_wr_last;
    tick         = (prescaler == '0) && !pause;
    timer_idle   = (ms_remaining == '0);
    swap         = (state == READY) && timer_idle && i_drv_frame_end && !pause;
    underrun_now = (state == FILL) && timer_idle && i_drv_frame_end && !pause;
    o_wr_ready   = (state == FILL);
  end

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (fill_done) state_next = READY;
      READY:   if (swap) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Write port: one-cycle registered copy of each accepted beat into the back bank.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr        <= '0;
      pending_delay  <= '0;
      o_ram_w_enable <= 1'b0;
      o_ram_w_addr   <= '0;
      o_ram_w_data   <= '0;
      o_wr_error     <= 1'b0;
    end else begin
      o_ram_w_enable <= accept;
      if (accept) begin
        o_ram_w_addr <= {~o_read_bank, wr_addr};
        o_ram_w_data <= i_wr_data;
      end
      if (fill_done) begin
        wr_addr       <= '0;
        pending_delay <= i_wr_delay_ms;
      end else if (accept) begin
        wr_addr <= wr_addr + ADDR_W'(1);
      end
      if (overflow) o_wr_error <= 1'b1;
    end
  end

  // Display timer and swap bookkeeping; a swap restarts the ms interval from a fresh prescaler.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      prescaler     <= PRE_MAX;
      ms_remaining  <= '0;
      o_read_bank   <= 1'b0;
      o_swap_stb    <= 1'b0;
      o_frame_count <= 8'd0;
      o_underrun    <= 1'b0;
    end else begin
      o_swap_stb <= swap;
      o_underrun <= underrun_now;
      if (swap) begin
        prescaler     <= PRE_MAX;
        ms_remaining  <= pending_delay;
        o_read_bank   <= ~o_read_bank;
        o_frame_count <= o_frame_count + 8'd1;
      end else if (!pause) begin
        if (tick) begin
          prescaler <= PRE_MAX;
          if (!timer_idle) ms_remaining <= ms_remaining - DELAY_W'(1);
        end else begin
          prescaler <= prescaler - PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/frame_swap_scheduler.md
Name: frame_swap_scheduler

Overview:
Double-buffer controller for the shared pixel RAM. A frame source (GIF decoder or test pattern) fills the back bank through a valid/ready stream. The panel driver scans the front bank. The block swaps banks only at a panel end-of-scan, and only once the current frame's display delay in milliseconds has expired. It owns the RAM write port and the MSB of the RAM read address.

Parameters:
ADDR_W, 11, bank-local pixel address width (2^ADDR_W pixels per bank; RAM address is ADDR_W+1 bits)
DATA_W, 16, pixel word width
TICK_DIV, 48000, i_clk cycles per 1 ms tick (48 MHz)
DELAY_W, 16, width of the per-frame delay in ms

Ports:
i_clk  in  1  system clock (48 MHz)
i_reset  in  1  asynchronous, active-high reset
i_wr_valid  in  1  source has a pixel
o_wr_ready  out  1  block accepts a pixel
i_wr_data  in  DATA_W  pixel word
i_wr_last  in  1  final pixel of the frame
i_wr_delay_ms  in  DELAY_W  display time for this frame; sampled on the last beat
o_ram_w_addr  out  ADDR_W+1  {write bank, pixel address}
o_ram_w_data  out  DATA_W  RAM write data
o_ram_w_enable  out  1  RAM write strobe
o_read_bank  out  1  front bank; the top level concatenates it as the RAM read-address MSB
i_drv_frame_end  in  1  one-cycle pulse from the panel driver after a complete scan
o_swap_stb  out  1  one-cycle pulse on a bank swap
o_frame_count  out  8  number of swaps, wraps at 255->0
o_underrun  out  1  one-cycle pulse when a swap is due but the back buffer is not ready
o_wr_error  out  1  sticky flag: a frame overflowed the bank

Behaviour:
- Reset values: o_read_bank=0, write bank=1, state=FILL, wr_addr=0, ms_remaining=0, prescaler=TICK_DIV-1. o_ram_w_enable, o_swap_stb, o_underrun, o_wr_error, o_frame_count and o_ram_w_addr/data are all 0.
- o_wr_ready = (state==FILL), combinational from state. It is 1 during reset.
- States:
  - FILL: accepting pixels.
  - READY: back bank complete, waiting for a swap.
- Accept = i_wr_valid && o_wr_ready.
- On accept, registered with 1-cycle latency:
  - o_ram_w_enable=1
  - o_ram_w_addr={~o_read_bank, wr_addr}
  - o_ram_w_data=i_wr_data
  - wr_addr increments.
- FILL->READY on an accept with i_wr_last=1, or on an accept at wr_addr=2^ADDR_W-1. In the second case with i_wr_last=0, set o_wr_error (sticky until reset) and ignore the remainder.
- On the READY entry edge, latch pending_delay=i_wr_delay_ms and clear wr_addr.
- ms timer:
  - The prescaler counts down from TICK_DIV-1 to 0; a tick occurs at 0 and the prescaler reloads.
  - On each tick, ms_remaining decrements, saturating at 0.
- Swap condition: state==READY && ms_remaining==0 && i_drv_frame_end.
- Registered effects of a swap:
  - o_read_bank toggles.
  - ms_remaining=pending_delay; the prescaler reloads.
  - state returns to FILL.
  - o_swap_stb pulses for 1 cycle; o_frame_count increments.
- Underrun condition: state==FILL && ms_remaining==0 && i_drv_frame_end. Raise a 1-cycle o_underrun; the front bank is redisplayed.
- Frame end arriving while ms_remaining>0: no action.
- Last beat accepted in the same cycle as a qualifying frame_end: state is still FILL at that edge, so o_underrun pulses and the swap waits for the next frame_end.
- pending_delay=0: swap at the first frame_end after READY.
- The final RAM write lands no later than the swap edge, so the driver never reads an incomplete bank after a swap.
- Asynchronous reset mid-frame: everything returns to reset values immediately; a partial back bank is discarded.

Optional Feature:
FRAME_PAUSE_EN
- Defined: adds input i_pause (1 bit). While i_pause=1:
  - the prescaler and ms_remaining hold;
  - swaps are inhibited;
  - o_underrun is suppressed;
  - FILL continues.
  - Release resumes the countdown from the held value.
- Undefined: no i_pause port; behaviour is identical to i_pause tied 0.

Test Plan:
All tests use TICK_DIV=4, ADDR_W=3.
1. Reset release, stream 8 beats 0x0001..0x0008 with last on beat 8, delay=2 -> RAM writes at addresses 8..15 with matching data, each one cycle after its accept. o_wr_ready=0 after beat 8.
2. From test 1, pulse frame_end at once (ms_remaining=0) -> o_swap_stb=1, o_read_bank=1, o_frame_count=1. A further frame_end before 8 clocks (2 ms) elapse -> no swap even after the next frame is READY. Swap occurs at the first frame_end after 8 clocks.
3. Pulse frame_end while in FILL with ms_remaining=0 -> o_underrun 1-cycle pulse; o_read_bank unchanged.
4. Stream 8 beats with i_wr_last=0 -> o_wr_error=1, state READY, beat 9 not accepted (o_wr_ready=0).
5. Assert i_reset after 3 beats -> all outputs at reset values in the same cycle. A new frame then writes starting at address 8.
6. With FRAME_PAUSE_EN defined: hold i_pause=1 for 40 clocks with frame_end pulses -> no swap and no underrun. Release -> swap at the first frame_end after the remaining delay expires.
